// File: rtl/jtcop_mcu_pkg.sv
// Shared types and constants for the 68000-side i8751 MCU mailbox host.
package jtcop_mcu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } mcu_state_t;

    // P2 pin roles as driven by the MCU firmware
    localparam int P2_ACK = 3;  // low = command noticed
    localparam int P2_RDH = 4;  // MCU fetches command high byte
    localparam int P2_RDL = 5;  // MCU fetches command low byte
    localparam int P2_WRL = 6;  // MCU presents reply low byte
    localparam int P2_WRH = 7;  // MCU presents reply high byte

    // Status word bit positions
    localparam int ST_RDY  = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_ERR  = 2;

endpackage

// File: rtl/jtcop_mcu_edge.sv
// Registered rising-edge detector. The delay register resets to all ones so
// inputs that are already high when reset releases do not look like edges.
module jtcop_mcu_edge #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] dly_q;

    // One-cycle delay of the input vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dly_q <= '1;
        else     dly_q <= d_i;
    end

    assign rise_o = d_i & ~dly_q;

endmodule

// File: rtl/jtcop_mcu_host.sv
// Main-CPU side of the MCU mailbox: latches a command word, raises INT1,
// serves the command bytes on P0, collects the two reply bytes and reports
// completion through status, an optional interrupt and a handshake timeout.
module jtcop_mcu_host
    import jtcop_mcu_pkg::*;
#(
    parameter int TOUT_W = 12,
    parameter bit IRQ_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        rnw,
    input  logic [1:0]  dsn,
    input  logic        addr,
    input  logic [15:0] cpu_dout,
    output logic [15:0] dout,
    output logic        irq_n,
    input  logic [7:0]  p0_o,
    output logic [7:0]  p0_i,
    input  logic [7:0]  p2_o,
    output logic        int1n
);

    mcu_state_t        st_q, st_d;
    logic [15:0]       latch_q, latch_d;
    logic [15:0]       reply_q, reply_d;
    logic [15:0]       dout_q, dout_d;
    logic [7:0]        p0_q, p0_d;
    logic [TOUT_W-1:0] cnt_q, cnt_d;
    logic              rdy_q, rdy_d;
    logic              err_q, err_d;
    logic              got_lo_q, got_lo_d;
    logic              got_hi_q, got_hi_d;
    logic              int1n_q, int1n_d;
    logic              irq_n_q, irq_n_d;

    logic [7:0]  p2_rise;
    logic        cs_rise;
    logic        busy;
    logic        done_now;
    logic [15:0] status;
    logic        unused_p2;

    jtcop_mcu_edge #(.W(8)) u_p2_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (p2_o),
        .rise_o (p2_rise)
    );

    // A CPU access acts only on the first cycle of cs
    jtcop_mcu_edge #(.W(1)) u_cs_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (cs),
        .rise_o (cs_rise)
    );

    // ACK is a level, bits 0..2 carry nothing for this protocol
    assign unused_p2 = ^p2_rise[3:0];

    assign busy     = (st_q == REQ) || (st_q == XFER);
    assign done_now = (st_q == XFER) && got_lo_q && got_hi_q;

    // Status snapshot returned on a status read
    always_comb begin
        status          = '0;
        status[ST_RDY]  = rdy_q;
        status[ST_BUSY] = busy;
        status[ST_ERR]  = err_q;
    end

    // Next-state: strobe service, handshake FSM, timeout, then CPU access
    always_comb begin
        st_d     = st_q;
        latch_d  = latch_q;
        reply_d  = reply_q;
        dout_d   = dout_q;
        p0_d     = p0_q;
        cnt_d    = cnt_q;
        rdy_d    = rdy_q;
        err_d    = err_q;
        got_lo_d = got_lo_q;
        got_hi_d = got_hi_q;
        int1n_d  = int1n_q;
        irq_n_d  = irq_n_q;

        // Strobes are honoured as soon as the request is raised, even
        // before the MCU acknowledges INT1
        if (busy) begin
            if (p2_rise[P2_RDH]) p0_d = latch_q[15:8];
            if (p2_rise[P2_RDL]) p0_d = latch_q[7:0];
            if (p2_rise[P2_WRL]) begin
                reply_d[7:0] = p0_o;
                got_lo_d     = 1'b1;
            end
            if (p2_rise[P2_WRH]) begin
                reply_d[15:8] = p0_o;
                got_hi_d      = 1'b1;
            end
            cnt_d = cnt_q + TOUT_W'(1);
        end

        case (st_q)
            REQ: begin
                if (!p2_o[P2_ACK]) begin
                    int1n_d = 1'b1;
                    st_d    = XFER;
                end
            end
            XFER: begin
                if (done_now) begin
                    rdy_d   = 1'b1;
                    irq_n_d = ~IRQ_EN;
                    st_d    = DONE;
                end
            end
            default: ;
        endcase

        // A reply that is complete in the last counted cycle still counts
        if (busy && (cnt_q == {TOUT_W{1'b1}}) && !done_now) begin
            err_d   = 1'b1;
            int1n_d = 1'b1;
            st_d    = IDLE;
        end

        // CPU access overrides everything above in the same cycle
        if (cs_rise && !addr) begin
            if (!rnw) begin
                if (!dsn[1]) latch_d[15:8] = cpu_dout[15:8];
                if (!dsn[0]) latch_d[7:0]  = cpu_dout[7:0];
                rdy_d    = 1'b0;
                err_d    = 1'b0;
                got_lo_d = 1'b0;
                got_hi_d = 1'b0;
                cnt_d    = '0;
                int1n_d  = 1'b0;
                irq_n_d  = 1'b1;
                st_d     = REQ;
            end else begin
                dout_d = reply_q;
                if (rdy_q) begin
                    rdy_d   = 1'b0;
                    irq_n_d = 1'b1;
                    st_d    = IDLE;
                end
            end
        end else if (cs_rise && rnw) begin
            dout_d = status;
        end
    end

    // State register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= IDLE;
            latch_q  <= '0;
            reply_q  <= '0;
            dout_q   <= '0;
            p0_q     <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
            got_lo_q <= 1'b0;
            got_hi_q <= 1'b0;
            int1n_q  <= 1'b1;
            irq_n_q  <= 1'b1;
        end else begin
            st_q     <= st_d;
            latch_q  <= latch_d;
            reply_q  <= reply_d;
            dout_q   <= dout_d;
            p0_q     <= p0_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
            err_q    <= err_d;
            got_lo_q <= got_lo_d;
            got_hi_q <= got_hi_d;
            int1n_q  <= int1n_d;
            irq_n_q  <= irq_n_d;
        end
    end

    assign dout  = dout_q;
    assign p0_i  = p0_q;
    assign int1n = int1n_q;
    assign irq_n = irq_n_q;

endmodule

// File: tb/tb_jtcop_mcu_host.sv
// Bench for the MCU mailbox host: directed protocol steps followed by random
// command/reply transactions checked against a byte-level mailbox model.
// A second instance with a short timeout and no CPU interrupt covers those
// options.
module tb_jtcop_mcu_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0, cs_t = 1'b0;
    logic        rnw = 1'b1;
    logic [1:0]  dsn = 2'b11;
    logic        addr = 1'b0;
    logic [15:0] cpu_dout = '0;
    logic [7:0]  p0_o = '0;
    logic [7:0]  p2_o = 8'h08;   // ACK released, strobes low

    logic [15:0] dout, dout_t;
    logic        irq_n, irq_n_t, int1n, int1n_t;
    logic [7:0]  p0_i, p0_i_t;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Mailbox model: command word held by the host, reply bytes from the MCU
    logic [15:0] m_latch;
    logic [7:0]  m_rlo, m_rhi;
    logic [15:0] v;

    jtcop_mcu_host #(.TOUT_W(8), .IRQ_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .cs(cs), .rnw(rnw), .dsn(dsn), .addr(addr),
        .cpu_dout(cpu_dout), .dout(dout), .irq_n(irq_n), .p0_o(p0_o),
        .p0_i(p0_i), .p2_o(p2_o), .int1n(int1n)
    );

    jtcop_mcu_host #(.TOUT_W(4), .IRQ_EN(1'b0)) dut_t (
        .clk(clk), .rst(rst), .cs(cs_t), .rnw(rnw), .dsn(dsn), .addr(addr),
        .cpu_dout(cpu_dout), .dout(dout_t), .irq_n(irq_n_t), .p0_o(p0_o),
        .p0_i(p0_i_t), .p2_o(p2_o), .int1n(int1n_t)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input bit t, input logic [15:0] d, input logic [1:0] m);
        addr = 1'b0; rnw = 1'b0; cpu_dout = d; dsn = m;
        if (t) cs_t = 1'b1; else cs = 1'b1;
        tick();
        cs = 1'b0; cs_t = 1'b0; rnw = 1'b1; dsn = 2'b11;
        tick();
    endtask

    task automatic rd(input bit t, input logic a, output logic [15:0] q);
        addr = a; rnw = 1'b1;
        if (t) cs_t = 1'b1; else cs = 1'b1;
        tick();
        q = t ? dout_t : dout;
        cs = 1'b0; cs_t = 1'b0;
        tick();
    endtask

    task automatic pulse(input int n);
        p2_o[n] = 1'b1;
        tick();
        p2_o[n] = 1'b0;
        tick();
    endtask

    task automatic ack();
        p2_o[3] = 1'b0;
        tick();
        p2_o[3] = 1'b1;
    endtask

    task automatic model_wr(input logic [15:0] d, input logic [1:0] m);
        if (!m[1]) m_latch[15:8] = d[15:8];
        if (!m[0]) m_latch[7:0]  = d[7:0];
    endtask

    initial begin
        int n;
        logic [15:0] d;
        logic [1:0]  m;

        m_latch = 16'h0000;
        #22;
        chk("rst_dout", dout, 16'h0000);
        chk("rst_int1n", 16'(int1n), 16'd1);
        chk("rst_irq_n", 16'(irq_n), 16'd1);
        chk("rst_p0_i", 16'(p0_i), 16'h0000);
        tick();
        rst = 1'b0;
        tick();

        // Basic transaction; low-byte fetch issued before ACK is honoured
        wr(0, 16'h1234, 2'b00); model_wr(16'h1234, 2'b00);
        chk("req_int1n", 16'(int1n), 16'd0);
        pulse(5);
        chk("fetch_in_req", 16'(p0_i), 16'(m_latch[7:0]));
        ack();
        chk("ack_int1n", 16'(int1n), 16'd1);
        rd(0, 1'b1, v); chk("st_busy", v, 16'h0002);
        pulse(4); chk("fetch_hi", 16'(p0_i), 16'h0012);
        pulse(5); chk("fetch_lo", 16'(p0_i), 16'h0034);
        p0_o = 8'hCD; pulse(6);
        p0_o = 8'hAB; pulse(7);
        rd(0, 1'b1, v); chk("st_rdy", v, 16'h0001);
        chk("irq_low", 16'(irq_n), 16'd0);
        rd(0, 1'b0, v); chk("reply", v, 16'hABCD);
        chk("irq_clr", 16'(irq_n), 16'd1);
        rd(0, 1'b1, v); chk("st_idle", v, 16'h0000);

        // Low-byte-only write merges into the previous command
        wr(0, 16'hFF56, 2'b10); model_wr(16'hFF56, 2'b10);
        ack();
        pulse(4); chk("mask_hi", 16'(p0_i), 16'h0012);
        pulse(5); chk("mask_lo", 16'(p0_i), 16'h0056);
        p2_o[5:4] = 2'b11; tick();
        chk("both_fetch", 16'(p0_i), 16'h0056);
        p2_o[5:4] = 2'b00; tick();

        // A write in XFER restarts: the earlier low reply byte no longer counts
        p0_o = 8'h11; pulse(6);
        wr(0, 16'hBEEF, 2'b00); model_wr(16'hBEEF, 2'b00);
        rd(0, 1'b1, v); chk("restart_st", v, 16'h0002);
        ack();
        p0_o = 8'h22; pulse(7);
        rd(0, 1'b1, v); chk("half_reply", v, 16'h0002);
        p0_o = 8'h33; pulse(6);
        rd(0, 1'b1, v); chk("restart_rdy", v, 16'h0001);
        rd(0, 1'b0, v); chk("restart_reply", v, 16'h2233);

        // Short-timeout instance: no ACK ever arrives
        wr(1, 16'h5A5A, 2'b00);
        n = 0;
        while (int1n_t === 1'b0 && n < 40) begin
            tick();
            n++;
        end
        chk("tout_cycles", 16'(n), 16'd15);
        rd(1, 1'b1, v); chk("tout_st", v, 16'h0004);
        rd(1, 1'b0, v); chk("tout_reply", v, 16'h0000);
        wr(1, 16'h0001, 2'b00);
        rd(1, 1'b1, v); chk("err_clr", v, 16'h0002);
        ack();
        p0_o = 8'h77; pulse(6);
        p0_o = 8'h88; pulse(7);
        rd(1, 1'b1, v); chk("noirq_rdy", v, 16'h0001);
        chk("noirq_irq", 16'(irq_n_t), 16'd1);
        rd(1, 1'b0, v); chk("noirq_reply", v, 16'h8877);

        // Asynchronous reset in the middle of XFER
        wr(0, 16'hC0DE, 2'b00);
        ack();
        pulse(4);
        p0_o = 8'h44; pulse(6);
        #2 rst = 1'b1;
        #1;
        chk("arst_p0_i", 16'(p0_i), 16'h0000);
        chk("arst_dout", dout, 16'h0000);
        chk("arst_int1n", 16'(int1n), 16'd1);
        chk("arst_irq_n", 16'(irq_n), 16'd1);
        chk("arst_p0_i_t", 16'(p0_i_t), 16'h0000);
        m_latch = 16'h0000;
        #3 rst = 1'b0;
        tick();
        rd(0, 1'b1, v); chk("arst_st", v, 16'h0000);

        // Random transactions
        for (int i = 0; i < 8; i++) begin
            d = 16'($urandom);
            m = 2'($urandom_range(0, 3));
            wr(0, d, m); model_wr(d, m);
            chk("r_int1n", 16'(int1n), 16'd0);
            rd(0, 1'b1, v); chk("r_busy", v, 16'h0002);
            ack();
            if ($urandom_range(0, 1) == 1) begin
                pulse(4); chk("r_fetch_hi", 16'(p0_i), 16'(m_latch[15:8]));
                pulse(5); chk("r_fetch_lo", 16'(p0_i), 16'(m_latch[7:0]));
            end else begin
                pulse(5); chk("r_fetch_lo", 16'(p0_i), 16'(m_latch[7:0]));
                pulse(4); chk("r_fetch_hi", 16'(p0_i), 16'(m_latch[15:8]));
            end
            m_rlo = 8'($urandom);
            m_rhi = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                p0_o = m_rhi; pulse(7);
                p0_o = m_rlo; pulse(6);
            end else begin
                p0_o = m_rlo; pulse(6);
                p0_o = m_rhi; pulse(7);
            end
            rd(0, 1'b1, v); chk("r_rdy", v, 16'h0001);
            chk("r_irq", 16'(irq_n), 16'd0);
            rd(0, 1'b0, v); chk("r_reply", v, {m_rhi, m_rlo});
            chk("r_irq_clr", 16'(irq_n), 16'd1);
        end

        // Write with cs held high throughout: must not keep restarting
        addr = 1'b0; rnw = 1'b0; cpu_dout = 16'h4321; dsn = 2'b00; cs = 1'b1;
        model_wr(16'h4321, 2'b00);
        tick();
        ack();
        pulse(4); chk("hold_fetch", 16'(p0_i), 16'(m_latch[15:8]));
        p0_o = 8'h9C; pulse(6);
        p0_o = 8'hE1; pulse(7);
        cs = 1'b0; rnw = 1'b1; dsn = 2'b11;
        tick();
        rd(0, 1'b1, v); chk("hold_wr_rdy", v, 16'h0001);

        // Read with cs held for ten cycles consumes the reply once
        addr = 1'b0; rnw = 1'b1; cs = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("hold_rd_reply", dout, 16'hE19C);
        chk("hold_rd_irq", 16'(irq_n), 16'd1);
        cs = 1'b0;
        tick();
        rd(0, 1'b1, v); chk("hold_rd_st", v, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
